// File: rtl/sram_port_arbiter_if.sv
// Bus bundle for sram_port_arbiter: both requester ports plus the SRAM controller port.
// The master modport is the arbiter's view; slave is the view of the requesters and controller.
interface sram_port_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  logic              req0;
  logic              req1;
  logic              wr0;
  logic              wr1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              wait0;
  logic              wait1;
  logic              done0;
  logic              done1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              m_req;
  logic              m_wr;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_ack;
  logic [DATA_W-1:0] m_rdata;
  logic              grant;

  modport master (
    input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, m_ack, m_rdata,
    output wait0, wait1, done0, done1, rdata0, rdata1,
           m_req, m_wr, m_addr, m_wdata, grant
  );

  modport slave (
    output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, m_ack, m_rdata,
    input  wait0, wait1, done0, done1, rdata0, rdata1,
           m_req, m_wr, m_addr, m_wdata, grant
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM controller port between the core (port 0) and the scanner (port 1).
// Round-robin by default; define ARB_FIXED_PRIO_EN to give port 0 fixed priority.
module sram_port_arbiter #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  sram_port_arbiter_if.master  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, RESP} state_e;

  state_e            state_q, state_d;
  logic              m_wr_q, m_wr_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              grant_q, grant_d;
  logic              winner;
  logic              done0, done1;
`ifndef ARB_FIXED_PRIO_EN
  logic              last_grant_q, last_grant_d;
`endif

`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    winner = bus.req0 ? 1'b0 : 1'b1;
  end
`else
  // On a tie the port that did not own the last completed transaction wins.
  always_comb begin
    if (bus.req0 && bus.req1) winner = ~last_grant_q;
    else                      winner = bus.req0 ? 1'b0 : 1'b1;
  end
`endif

  always_comb begin
    state_d   = state_q;
    m_wr_d    = m_wr_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    grant_d   = grant_q;
`ifndef ARB_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          grant_d   = winner;
          m_wr_d    = winner ? bus.wr1    : bus.wr0;
          m_addr_d  = winner ? bus.addr1  : bus.addr0;
          m_wdata_d = winner ? bus.wdata1 : bus.wdata0;
          state_d   = ISSUE;
        end
      end
      ISSUE, WAIT_ACK: begin
        if (bus.m_ack) begin
          if (!m_wr_q) begin
            if (grant_q) rdata1_d = bus.m_rdata;
            else         rdata0_d = bus.m_rdata;
          end
          state_d = RESP;
        end else begin
          state_d = WAIT_ACK;
        end
      end
      RESP: begin
`ifndef ARB_FIXED_PRIO_EN
        last_grant_d = grant_q;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= IDLE;
      m_wr_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      grant_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_wr_q    <= m_wr_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      grant_q   <= grant_d;
    end
  end

`ifndef ARB_FIXED_PRIO_EN
  // Reset to 1 so port 0 wins the first tie.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) last_grant_q <= 1'b1;
    else        last_grant_q <= last_grant_d;
  end
`endif

  assign done0       = (state_q == RESP) && !grant_q;
  assign done1       = (state_q == RESP) &&  grant_q;
  assign bus.done0   = done0;
  assign bus.done1   = done1;
  assign bus.wait0   = bus.req0 && !done0;
  assign bus.wait1   = bus.req1 && !done1;
  assign bus.rdata0  = rdata0_q;
  assign bus.rdata1  = rdata1_q;
  assign bus.m_req   = (state_q == ISSUE);
  assign bus.m_wr    = m_wr_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.grant   = grant_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed testbench for sram_port_arbiter; inputs change and outputs are sampled on the falling edge.
module tb_sram_port_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  sram_port_arbiter_if #(.ADDR_W(20), .DATA_W(16)) bus ();

  sram_port_arbiter #(.ADDR_W(20), .DATA_W(16)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    @(negedge clk);
    checks++; if (bus.m_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_req: got %b expected 0", bus.m_req); end
    checks++; if (bus.m_wr !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_wr: got %b expected 0", bus.m_wr); end
    checks++; if ({bus.done0, bus.done1} !== 2'b00) begin errors++; $display("[TB] FAIL reset_done: got %b expected 00", {bus.done0, bus.done1}); end
    checks++; if (bus.m_addr !== 20'h0) begin errors++; $display("[TB] FAIL reset_m_addr: got %h expected 00000", bus.m_addr); end
    checks++; if (bus.m_wdata !== 16'h0) begin errors++; $display("[TB] FAIL reset_m_wdata: got %h expected 0000", bus.m_wdata); end
    checks++; if ({bus.rdata0, bus.rdata1} !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata: got %h expected 00000000", {bus.rdata0, bus.rdata1}); end
    checks++; if (bus.grant !== 1'b0) begin errors++; $display("[TB] FAIL reset_grant: got %b expected 0", bus.grant); end
  endtask

  task automatic test_single_read();
    @(negedge clk);
    bus.req0 = 1'b1; bus.wr0 = 1'b0; bus.addr0 = 20'h00123;
    #1;
    checks++; if (bus.wait0 !== 1'b1) begin errors++; $display("[TB] FAIL read_wait0: got %b expected 1", bus.wait0); end
    @(negedge clk);
    checks++; if (bus.m_req !== 1'b1) begin errors++; $display("[TB] FAIL read_m_req: got %b expected 1", bus.m_req); end
    checks++; if (bus.m_addr !== 20'h00123) begin errors++; $display("[TB] FAIL read_m_addr: got %h expected 00123", bus.m_addr); end
    checks++; if (bus.m_wr !== 1'b0) begin errors++; $display("[TB] FAIL read_m_wr: got %b expected 0", bus.m_wr); end
    @(negedge clk);
    checks++; if (bus.m_req !== 1'b0) begin errors++; $display("[TB] FAIL read_m_req_drop: got %b expected 0", bus.m_req); end
    checks++; if (bus.done0 !== 1'b0) begin errors++; $display("[TB] FAIL read_done0_early: got %b expected 0", bus.done0); end
    bus.m_ack = 1'b1; bus.m_rdata = 16'hBEEF;
    @(negedge clk);
    bus.m_ack = 1'b0;
    checks++; if (bus.done0 !== 1'b1) begin errors++; $display("[TB] FAIL read_done0: got %b expected 1", bus.done0); end
    checks++; if (bus.rdata0 !== 16'hBEEF) begin errors++; $display("[TB] FAIL read_rdata0: got %h expected BEEF", bus.rdata0); end
    checks++; if (bus.wait0 !== 1'b0) begin errors++; $display("[TB] FAIL read_wait0_done: got %b expected 0", bus.wait0); end
    bus.req0 = 1'b0;
    @(negedge clk);
    checks++; if (bus.done0 !== 1'b0) begin errors++; $display("[TB] FAIL read_done0_pulse: got %b expected 0", bus.done0); end
    checks++; if (bus.rdata0 !== 16'hBEEF) begin errors++; $display("[TB] FAIL read_rdata0_hold: got %h expected BEEF", bus.rdata0); end
  endtask

  task automatic test_single_write();
    bus.req1 = 1'b1; bus.wr1 = 1'b1; bus.addr1 = 20'h001A0; bus.wdata1 = 16'h5A5A;
    @(negedge clk);
    checks++; if (bus.m_req !== 1'b1) begin errors++; $display("[TB] FAIL write_m_req: got %b expected 1", bus.m_req); end
    checks++; if (bus.m_wr !== 1'b1) begin errors++; $display("[TB] FAIL write_m_wr: got %b expected 1", bus.m_wr); end
    checks++; if (bus.m_wdata !== 16'h5A5A) begin errors++; $display("[TB] FAIL write_m_wdata: got %h expected 5A5A", bus.m_wdata); end
    checks++; if (bus.m_addr !== 20'h001A0) begin errors++; $display("[TB] FAIL write_m_addr: got %h expected 001A0", bus.m_addr); end
    checks++; if (bus.grant !== 1'b1) begin errors++; $display("[TB] FAIL write_grant: got %b expected 1", bus.grant); end
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      checks++; if ({bus.wait1, bus.done1, bus.m_req} !== 3'b100) begin errors++; $display("[TB] FAIL write_waiting[%0d]: got wait1/done1/m_req=%b expected 100", i, {bus.wait1, bus.done1, bus.m_req}); end
    end
    bus.m_ack = 1'b1; bus.m_rdata = 16'hFFFF;
    @(negedge clk);
    bus.m_ack = 1'b0;
    checks++; if (bus.done1 !== 1'b1) begin errors++; $display("[TB] FAIL write_done1: got %b expected 1", bus.done1); end
    checks++; if (bus.wait1 !== 1'b0) begin errors++; $display("[TB] FAIL write_wait1_done: got %b expected 0", bus.wait1); end
    checks++; if (bus.rdata1 !== 16'h0000) begin errors++; $display("[TB] FAIL write_rdata1_unchanged: got %h expected 0000", bus.rdata1); end
    checks++; if (bus.rdata0 !== 16'hBEEF) begin errors++; $display("[TB] FAIL write_rdata0_unchanged: got %h expected BEEF", bus.rdata0); end
    bus.req1 = 1'b0; bus.wr1 = 1'b0;
    @(negedge clk);
    checks++; if (bus.done1 !== 1'b0) begin errors++; $display("[TB] FAIL write_done1_pulse: got %b expected 0", bus.done1); end
  endtask

  task automatic test_contention();
    logic        exp;
    logic [15:0] val;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    bus.req0 = 1'b1; bus.wr0 = 1'b0; bus.addr0 = 20'h00A00;
    bus.req1 = 1'b1; bus.wr1 = 1'b0; bus.addr1 = 20'h00B00;
    for (int t = 0; t < 4; t++) begin
`ifdef ARB_FIXED_PRIO_EN
      exp = 1'b0;
`else
      exp = t[0];
`endif
      val = 16'h1000 + 16'(t);
      @(negedge clk);
      checks++; if (bus.grant !== exp) begin errors++; $display("[TB] FAIL contention_grant[%0d]: got %b expected %b", t, bus.grant, exp); end
      checks++; if (bus.m_addr !== (exp ? 20'h00B00 : 20'h00A00)) begin errors++; $display("[TB] FAIL contention_m_addr[%0d]: got %h expected %h", t, bus.m_addr, exp ? 20'h00B00 : 20'h00A00); end
      @(negedge clk);
      bus.m_ack = 1'b1; bus.m_rdata = val;
      @(negedge clk);
      bus.m_ack = 1'b0;
      checks++; if ({bus.done1, bus.done0} !== (exp ? 2'b10 : 2'b01)) begin errors++; $display("[TB] FAIL contention_done[%0d]: got done1/done0=%b expected %b", t, {bus.done1, bus.done0}, exp ? 2'b10 : 2'b01); end
      checks++; if ((exp ? bus.rdata1 : bus.rdata0) !== val) begin errors++; $display("[TB] FAIL contention_rdata[%0d]: got %h expected %h", t, exp ? bus.rdata1 : bus.rdata0, val); end
      if (t == 3) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
      @(negedge clk);
      checks++; if ({bus.m_req, bus.done0, bus.done1} !== 3'b000) begin errors++; $display("[TB] FAIL contention_idle[%0d]: got m_req/done0/done1=%b expected 000", t, {bus.m_req, bus.done0, bus.done1}); end
    end
  endtask

  task automatic test_ack_in_issue();
    bus.req0 = 1'b1; bus.wr0 = 1'b0; bus.addr0 = 20'h00055;
    @(negedge clk);
    checks++; if (bus.m_req !== 1'b1) begin errors++; $display("[TB] FAIL issue_ack_m_req: got %b expected 1", bus.m_req); end
    bus.m_ack = 1'b1; bus.m_rdata = 16'hCAFE;
    @(negedge clk);
    bus.m_ack = 1'b0;
    checks++; if (bus.done0 !== 1'b1) begin errors++; $display("[TB] FAIL issue_ack_done0: got %b expected 1", bus.done0); end
    checks++; if (bus.rdata0 !== 16'hCAFE) begin errors++; $display("[TB] FAIL issue_ack_rdata0: got %h expected CAFE", bus.rdata0); end
    bus.req0 = 1'b0;
    @(negedge clk);
    bus.m_ack = 1'b1; bus.m_rdata = 16'hDEAD;
    @(negedge clk);
    bus.m_ack = 1'b0;
    checks++; if ({bus.m_req, bus.done0, bus.done1} !== 3'b000) begin errors++; $display("[TB] FAIL stray_ack_idle: got m_req/done0/done1=%b expected 000", {bus.m_req, bus.done0, bus.done1}); end
    @(negedge clk);
    checks++; if ({bus.m_req, bus.done0, bus.done1} !== 3'b000) begin errors++; $display("[TB] FAIL stray_ack_after: got m_req/done0/done1=%b expected 000", {bus.m_req, bus.done0, bus.done1}); end
    checks++; if (bus.rdata0 !== 16'hCAFE) begin errors++; $display("[TB] FAIL stray_ack_rdata0: got %h expected CAFE", bus.rdata0); end
  endtask

  task automatic test_drop_alter();
    int doneCount;
    bus.req0 = 1'b1; bus.wr0 = 1'b0; bus.addr0 = 20'h00777;
    @(negedge clk);
    checks++; if (bus.m_addr !== 20'h00777) begin errors++; $display("[TB] FAIL drop_m_addr_issue: got %h expected 00777", bus.m_addr); end
    @(negedge clk);
    bus.req0 = 1'b0; bus.addr0 = 20'hFFFFF; bus.wr0 = 1'b1; bus.wdata0 = 16'h9999;
    #1;
    checks++; if (bus.wait0 !== 1'b0) begin errors++; $display("[TB] FAIL drop_wait0: got %b expected 0", bus.wait0); end
    @(negedge clk);
    checks++; if (bus.m_addr !== 20'h00777) begin errors++; $display("[TB] FAIL drop_m_addr_hold: got %h expected 00777", bus.m_addr); end
    checks++; if (bus.m_wr !== 1'b0) begin errors++; $display("[TB] FAIL drop_m_wr_hold: got %b expected 0", bus.m_wr); end
    bus.m_ack = 1'b1; bus.m_rdata = 16'h1234;
    doneCount = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.m_ack = 1'b0;
      if (bus.done0 === 1'b1) doneCount++;
    end
    checks++; if (doneCount !== 1) begin errors++; $display("[TB] FAIL drop_done0_count: got %0d expected 1", doneCount); end
    checks++; if (bus.rdata0 !== 16'h1234) begin errors++; $display("[TB] FAIL drop_rdata0: got %h expected 1234", bus.rdata0); end
    checks++; if (bus.m_req !== 1'b0) begin errors++; $display("[TB] FAIL drop_no_reissue: got %b expected 0", bus.m_req); end
    bus.wr0 = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    bus.req1 = 1'b1; bus.wr1 = 1'b0; bus.addr1 = 20'h00999;
    @(negedge clk);
    checks++; if (bus.grant !== 1'b1) begin errors++; $display("[TB] FAIL rstwait_grant_before: got %b expected 1", bus.grant); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (bus.grant !== 1'b0) begin errors++; $display("[TB] FAIL rstwait_grant: got %b expected 0", bus.grant); end
    checks++; if ({bus.m_req, bus.m_wr, bus.done0, bus.done1} !== 4'b0000) begin errors++; $display("[TB] FAIL rstwait_ctrl: got m_req/m_wr/done0/done1=%b expected 0000", {bus.m_req, bus.m_wr, bus.done0, bus.done1}); end
    checks++; if (bus.m_addr !== 20'h0) begin errors++; $display("[TB] FAIL rstwait_m_addr: got %h expected 00000", bus.m_addr); end
    checks++; if ({bus.rdata0, bus.rdata1} !== 32'h0) begin errors++; $display("[TB] FAIL rstwait_rdata: got %h expected 00000000", {bus.rdata0, bus.rdata1}); end
    @(negedge clk);
    rst = 1'b1;
    bus.req0 = 1'b1; bus.wr0 = 1'b0; bus.addr0 = 20'h00AAA;
    bus.addr1 = 20'h00BBB;
    @(negedge clk);
    checks++; if (bus.grant !== 1'b0) begin errors++; $display("[TB] FAIL rstwait_tie_grant: got %b expected 0", bus.grant); end
    checks++; if (bus.m_addr !== 20'h00AAA) begin errors++; $display("[TB] FAIL rstwait_tie_m_addr: got %h expected 00AAA", bus.m_addr); end
    @(negedge clk);
    bus.m_ack = 1'b1; bus.m_rdata = 16'h7777;
    @(negedge clk);
    bus.m_ack = 1'b0;
    checks++; if (bus.done0 !== 1'b1) begin errors++; $display("[TB] FAIL rstwait_done0: got %b expected 1", bus.done0); end
    checks++; if (bus.rdata0 !== 16'h7777) begin errors++; $display("[TB] FAIL rstwait_rdata0: got %h expected 7777", bus.rdata0); end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.req0 = 1'b0; bus.wr0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.wr1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    bus.m_ack = 1'b0; bus.m_rdata = '0;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b1;
    test_single_read();
    test_single_write();
    test_contention();
    test_ack_in_issue();
    test_drop_alter();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
